// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
//   Sequences the branch-predictor update port. Resolved conditional branches
//   from EX are buffered in a small FIFO and drained one per cycle into the
//   predictor's single update/waddr/br_en port. Also converts the core's
//   asynchronous active-low reset into the predictor's synchronous
//   active-high table-init reset (bp_rst), held for INIT_CYCLES edges.
//
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   PTR_W        $clog2(DEPTH)
//   INIT_CYCLES  rising edges bp_rst stays high after rst_n release (>= 1)
//
// Ports
//   clk, rst_n          core clock, async active-low reset
//   ex_valid/ex_pc/ex_br_en/ex_ready   EX-side push handshake
//   bp_hold             suppress draining this cycle
//   bp_rst              sync active-high predictor reset
//   bp_update/bp_waddr/bp_br_en        predictor update port (head entry)
//   bp_mispred          predictor mispredict for current bp_waddr
//   occupancy           current FIFO entry count
//   perf_br_cnt         updates issued
//   perf_mispred_cnt    updates issued with bp_mispred=1
//
// Build option
//   BP_PERF_CNT_EN  defined: performance counters implemented.
//                   undefined: no counter flops, perf outputs tied to zero.
// ---------------------------------------------------------------------------
module bp_update_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PTR_W       = 2,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               ex_br_en,
  output logic               ex_ready,
  input  logic               bp_hold,
  output logic               bp_rst,
  output logic               bp_update,
  output logic [31:0]        bp_waddr,
  output logic               bp_br_en,
  input  logic               bp_mispred,
  output logic [PTR_W:0]     occupancy,
  output logic [31:0]        perf_br_cnt,
  output logic [31:0]        perf_mispred_cnt
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  localparam logic [PTR_W:0] DEPTH_C    = (PTR_W+1)'(DEPTH);
  localparam logic [31:0]    INIT_LAST  = 32'(INIT_CYCLES - 1);

  state_t           state;
  logic [31:0]      init_cnt;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [31:0]      mem_pc [DEPTH];
  logic             mem_en [DEPTH];

  logic             push;
  logic             pop;

  // Readiness depends only on registered state: a full queue stays closed
  // even in a cycle where the head is being drained.
  always_comb begin
    ex_ready  = (state == S_RUN) && (count < DEPTH_C);
    bp_update = (state == S_RUN) && (count != '0) && !bp_hold;
    push      = ex_valid && ex_ready;
    pop       = bp_update;
    bp_waddr  = '0;
    bp_br_en  = 1'b0;
    if (count != '0) begin
      bp_waddr = mem_pc[head];
      bp_br_en = mem_en[head];
    end
  end

  assign occupancy = count;

  // Control FSM, pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
      bp_rst   <= 1'b1;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 32'd1;
          if (init_cnt == INIT_LAST) begin
            state  <= S_RUN;
            bp_rst <= 1'b0;
          end
        end
        S_RUN: begin
          bp_rst <= 1'b0;
        end
        default: begin
          state  <= S_INIT;
          bp_rst <= 1'b1;
        end
      endcase

      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: reads are masked while count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail] <= ex_pc;
      mem_en[tail] <= ex_br_en;
    end
  end

`ifdef BP_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt      <= '0;
      perf_mispred_cnt <= '0;
    end else if (bp_update) begin
      perf_br_cnt <= perf_br_cnt + 32'd1;
      if (bp_mispred) perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
    end
  end
`else
  logic unused_mispred;
  assign unused_mispred   = bp_mispred;
  assign perf_br_cnt      = '0;
  assign perf_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
module tb_bp_update_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic        ex_ready;
  logic        bp_hold;
  logic        bp_rst;
  logic        bp_update;
  logic [31:0] bp_waddr;
  logic        bp_br_en;
  logic        bp_mispred;
  logic [2:0]  occupancy;
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mispred_cnt;

  int unsigned vectors;
  int unsigned miscompares;
  logic [32:0] sb[$];
  logic [32:0] e;

  bp_update_ctrl #(.DEPTH(4), .PTR_W(2), .INIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_en(ex_br_en), .ex_ready(ex_ready),
    .bp_hold(bp_hold), .bp_rst(bp_rst),
    .bp_update(bp_update), .bp_waddr(bp_waddr), .bp_br_en(bp_br_en),
    .bp_mispred(bp_mispred), .occupancy(occupancy),
    .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed just after a falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic v, input logic [31:0] pc, input logic en, input logic hold);
    ex_valid = v;
    ex_pc    = pc;
    ex_br_en = en;
    bp_hold  = hold;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    vectors++;
    if ({bp_rst, ex_ready, bp_update, occupancy} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got rst=%b rdy=%b upd=%b occ=%0d want 1 0 0 0", bp_rst, ex_ready, bp_update, occupancy);
    end
    vectors++;
    if ({perf_br_cnt, perf_mispred_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_br_cnt, perf_mispred_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({bp_rst, ex_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL init_edge1: got rst=%b rdy=%b want 1 0", bp_rst, ex_ready);
    end
    @(negedge clk); #1;
    vectors++;
    if ({bp_rst, ex_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL init_edge2: got rst=%b rdy=%b want 0 1", bp_rst, ex_ready);
    end
  endtask

  task automatic test_single;
    drive(1'b1, 32'h100, 1'b1, 1'b0); #1;
    vectors++;
    if (bp_update !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pre: got upd=%b want 0", bp_update);
    end
    if (ex_valid && ex_ready) sb.push_back({ex_pc, ex_br_en});
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    vectors++;
    if ({bp_update, bp_waddr, bp_br_en} !== {1'b1, 32'h100, 1'b1}) begin
      miscompares++;
      $display("FAIL single_update: got upd=%b addr=%h en=%b want 1 00000100 1", bp_update, bp_waddr, bp_br_en);
    end
    if (bp_update) void'(sb.pop_front());
    @(negedge clk); #1;
    vectors++;
    if ({bp_update, occupancy} !== {1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL single_drained: got upd=%b occ=%0d want 0 0", bp_update, occupancy);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h10 * (i + 1), i[0], 1'b1); #1;
      vectors++;
      if ({ex_ready, bp_update} !== 2'b10) begin
        miscompares++;
        $display("FAIL hold_fill%0d: got rdy=%b upd=%b want 1 0", i, ex_ready, bp_update);
      end
      if (ex_valid && ex_ready) sb.push_back({ex_pc, ex_br_en});
    end
    @(negedge clk);
    drive(1'b1, 32'h50, 1'b1, 1'b1); #1;
    vectors++;
    if ({occupancy, ex_ready, bp_update} !== {3'd4, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_full: got occ=%0d rdy=%b upd=%b want 4 0 0", occupancy, ex_ready, bp_update);
    end
    if (ex_valid && ex_ready) sb.push_back({ex_pc, ex_br_en});
    // Drop hold while still offering the 5th entry: full queue must refuse it.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(i == 0, 32'h50, 1'b1, 1'b0); #1;
      if (i == 0) begin
        vectors++;
        if ({ex_ready, bp_update} !== 2'b01) begin
          miscompares++;
          $display("FAIL full_pop_ready: got rdy=%b upd=%b want 0 1", ex_ready, bp_update);
        end
      end
      vectors++;
      if (!bp_update || sb.size() == 0) begin
        miscompares++;
        $display("FAIL hold_drain%0d: got upd=%b queued=%0d want 1 >0", i, bp_update, sb.size());
      end else begin
        e = sb.pop_front();
        if ({bp_waddr, bp_br_en} !== e) begin
          miscompares++;
          $display("FAIL hold_order%0d: got %h/%b want %h/%b", i, bp_waddr, bp_br_en, e[32:1], e[0]);
        end
      end
      if (ex_valid && ex_ready) sb.push_back({ex_pc, ex_br_en});
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0); #1;
    vectors++;
    if ({occupancy, bp_update} !== {3'd0, 1'b0} || sb.size() != 0) begin
      miscompares++;
      $display("FAIL hold_empty: got occ=%0d upd=%b left=%0d want 0 0 0", occupancy, bp_update, sb.size());
    end
  endtask

  task automatic test_stream;
    int unsigned n_upd;
    n_upd = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(i < 10, 32'h1000 + 32'(i) * 4, i[0], 1'b0); #1;
      if (i > 0) begin
        vectors++;
        if (occupancy !== 3'd1) begin
          miscompares++;
          $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy);
        end
      end
      if (bp_update) begin
        n_upd++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL stream_extra: got update %h want none", bp_waddr);
        end else begin
          e = sb.pop_front();
          if ({bp_waddr, bp_br_en} !== e) begin
            miscompares++;
            $display("FAIL stream_order%0d: got %h/%b want %h/%b", i, bp_waddr, bp_br_en, e[32:1], e[0]);
          end
        end
      end
      if (ex_valid && ex_ready) sb.push_back({ex_pc, ex_br_en});
    end
    vectors++;
    if (n_upd != 10 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL stream_count: got %0d updates left=%0d want 10 0", n_upd, sb.size());
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h700 + 32'(i), 1'b1, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    vectors++;
    if ({bp_rst, bp_update, occupancy, ex_ready} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL midreset: got rst=%b upd=%b occ=%0d rdy=%b want 1 0 0 0", bp_rst, bp_update, occupancy, ex_ready);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({bp_update, occupancy} !== {1'b0, 3'd0}) begin
        miscompares++;
        $display("FAIL stale_entry%0d: got upd=%b occ=%0d addr=%h want 0 0", i, bp_update, occupancy, bp_waddr);
      end
    end
  endtask

  task automatic test_perf;
    logic [31:0] exp_br;
    logic [31:0] exp_mis;
`ifdef BP_PERF_CNT_EN
    exp_br = 32'd6; exp_mis = 32'd2;
`else
    exp_br = 32'd0; exp_mis = 32'd0;
`endif
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(i < 6, 32'h200 + 32'(i) * 4, 1'b0, 1'b0); #1;
      bp_mispred = bp_update && (bp_waddr == 32'h204 || bp_waddr == 32'h20C);
      if (bp_update) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL perf_extra: got update %h want none", bp_waddr);
        end else begin
          e = sb.pop_front();
          if ({bp_waddr, bp_br_en} !== e) begin
            miscompares++;
            $display("FAIL perf_order%0d: got %h/%b want %h/%b", i, bp_waddr, bp_br_en, e[32:1], e[0]);
          end
        end
      end
      if (ex_valid && ex_ready) sb.push_back({ex_pc, ex_br_en});
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    bp_mispred = 1'b0; #1;
    vectors++;
    if ({perf_br_cnt, perf_mispred_cnt} !== {exp_br, exp_mis}) begin
      miscompares++;
      $display("FAIL perf_counts: got %0d/%0d want %0d/%0d", perf_br_cnt, perf_mispred_cnt, exp_br, exp_mis);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL perf_missing: got %0d undrained want 0", sb.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bp_mispred  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    test_reset;
    test_single;
    test_hold;
    test_stream;
    test_reset_mid;
    test_perf;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
